fetch_controller: RTL and testbench

- Fetch-side sequencer for the instruction buffer (IB).
- Generates the fetch PC and issues aligned fetch-block requests to the icache under credit-based flow control, derived from the IB `available_slots`.
- Converts in-order icache responses into `FETCH_PACKET` pushes.
- On a redirect (branch mispredict or exception), flushes the IB and squashes in-flight responses.

---
 rtl/fetch_controller_pkg.sv | 31 +++
 rtl/fetch_controller_pc_fifo.sv | 53 +++++
 rtl/fetch_controller.sv | 149 ++++++++++++++
 tb/tb_fetch_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller_pkg
// Description : Shared fetch/IB types and sizing constants.
// Revision    : 1.0
// ============================================================================
package fetch_controller_pkg;

    localparam int IB_PUSH_WIDTH = 4;
    localparam int IB_SZ         = 16;
    localparam int IB_IDX_BITS   = $clog2(IB_SZ);
    localparam int FB_BYTES_DEF  = IB_PUSH_WIDTH * 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
        logic        valid;
    } FETCH_PACKET;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] block_align(input logic [31:0] pc, input int fb_bytes);
        return pc & ~(32'(fb_bytes) - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_controller_pc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_fifo
// Description : FIFO of request PCs, one entry per outstanding icache request.
// Revision    : 1.0
// ============================================================================
module fetch_pc_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        i_clear,
    input  logic        i_push,
    input  logic [31:0] i_push_pc,
    input  logic        i_pop,
    output logic [31:0] o_head_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign o_head_pc = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_pc;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller
// Description : Credit-gated icache fetch sequencer feeding the IB; squashes
//               stale responses after redirects. Optional FETCH_PERF_EN
//               adds credit-stall and squash counters.
// Revision    : 1.0
// ============================================================================
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          FB_BYTES        = FB_BYTES_DEF
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [IB_IDX_BITS:0]            i_ib_available_slots,
    output FETCH_PACKET [IB_PUSH_WIDTH-1:0] o_ib_push,
    output logic                            o_ib_flush,
    output logic                            o_ic_req_valid,
    output logic [31:0]                     o_ic_req_addr,
    input  logic                            i_ic_req_ready,
    input  logic                            i_ic_resp_valid,
    input  logic [IB_PUSH_WIDTH*32-1:0]     i_ic_resp_data,
`ifdef FETCH_PERF_EN
    output logic [31:0]                     o_perf_credit_stall,
    output logic [31:0]                     o_perf_squashed,
`endif
    input  logic                            i_redirect_valid,
    input  logic [31:0]                     i_redirect_pc
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PROD_W = IB_IDX_BITS + 2;

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic [31:0]      r_fetch_pc;
    logic [CNT_W-1:0] r_inflight;
    logic [CNT_W-1:0] r_to_drop;
    logic [CNT_W-1:0] w_to_drop_next;
    logic [CNT_W-1:0] w_live;
    logic [PROD_W-1:0] w_need;
    logic             w_credit_ok;
    logic             w_room;
    logic             w_accept;
    logic             w_consume;
    logic             w_drop;
    logic [31:0]      w_head_pc;
    logic [31:0]      w_head_aligned;
    logic [31:0]      w_offset;

    assign w_live      = r_inflight - r_to_drop;
    assign w_need      = (PROD_W'(w_live) + PROD_W'(1)) * PROD_W'(IB_PUSH_WIDTH);
    assign w_credit_ok = {1'b0, i_ib_available_slots} >= w_need;
    assign w_room      = r_inflight < CNT_W'(MAX_OUTSTANDING);

    assign o_ic_req_valid = !reset && !i_redirect_valid && w_room && w_credit_ok;
    assign o_ic_req_addr  = block_align(r_fetch_pc, FB_BYTES);
    assign o_ib_flush     = !reset && i_redirect_valid;

    assign w_accept  = o_ic_req_valid && i_ic_req_ready;
    assign w_consume = i_ic_resp_valid && (r_inflight != '0);
    // Anything in flight when a redirect lands is stale, including a response in that same cycle.
    assign w_drop    = w_consume && (i_redirect_valid || (r_to_drop != '0));

    // Not cleared on redirect: dropped responses still pop their stale entries.
    fetch_pc_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_fifo (
        .clock     (clock),
        .i_clear   (reset),
        .i_push    (w_accept),
        .i_push_pc (r_fetch_pc),
        .i_pop     (w_consume),
        .o_head_pc (w_head_pc)
    );

    assign w_head_aligned = block_align(w_head_pc, FB_BYTES);
    assign w_offset       = (w_head_pc >> 2) % 32'(IB_PUSH_WIDTH);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
            r_inflight <= '0;
            r_to_drop  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= r_inflight + CNT_W'(w_accept) - CNT_W'(w_consume);
            r_to_drop  <= w_to_drop_next;
            if (i_redirect_valid)
                r_fetch_pc <= i_redirect_pc;
            else if (w_accept)
                r_fetch_pc <= o_ic_req_addr + 32'(FB_BYTES);
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_to_drop_next = r_to_drop;
        o_ib_push      = '0;

        if (i_redirect_valid)
            w_to_drop_next = r_inflight - CNT_W'(w_consume);
        else if (w_consume && (r_to_drop != '0))
            w_to_drop_next = r_to_drop - CNT_W'(1);

        case (r_state)
            ST_RUN:   if (i_redirect_valid && (w_to_drop_next != '0)) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_to_drop_next == '0) w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase

        if (!reset && w_consume && !w_drop) begin
            for (int i = 0; i < IB_PUSH_WIDTH; i++) begin
                if (32'(i) >= w_offset) begin
                    o_ib_push[i].inst  = i_ic_resp_data[32*i +: 32];
                    o_ib_push[i].PC    = w_head_aligned + 32'(4 * i);
                    o_ib_push[i].NPC   = w_head_aligned + 32'(4 * i + 4);
                    o_ib_push[i].valid = 1'b1;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_credit_stall;
    logic [31:0] r_perf_squashed;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_credit_stall <= '0;
            r_perf_squashed     <= '0;
        end else begin
            if (w_room && !w_credit_ok && (r_perf_credit_stall != '1))
                r_perf_credit_stall <= r_perf_credit_stall + 32'd1;
            if (w_drop && (r_perf_squashed != '1))
                r_perf_squashed <= r_perf_squashed + 32'd1;
        end
    end

    assign o_perf_credit_stall = r_perf_credit_stall;
    assign o_perf_squashed     = r_perf_squashed;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_controller
// Description : Directed scoreboard bench for fetch_controller (IB width 4,
//               IB size 16, two outstanding requests).
// Revision    : 1.0
// ============================================================================
module tb_fetch_controller;
    import fetch_controller_pkg::*;

    typedef FETCH_PACKET [IB_PUSH_WIDTH-1:0] push_t;

    logic                        clock = 1'b0;
    logic                        reset;
    logic [IB_IDX_BITS:0]        slots;
    push_t                       push;
    logic                        flush;
    logic                        req_valid;
    logic [31:0]                 req_addr;
    logic                        ready;
    logic                        resp_valid;
    logic [IB_PUSH_WIDTH*32-1:0] resp_data;
    logic                        redir;
    logic [31:0]                 redir_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]                 perf_stall;
    logic [31:0]                 perf_sq;
`endif

    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_fail   = 0;
    push_t sb [$];

    always #5 clock = ~clock;

    fetch_controller #(
        .RESET_PC        (32'h0),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .i_ib_available_slots (slots),
        .o_ib_push            (push),
        .o_ib_flush           (flush),
        .o_ic_req_valid       (req_valid),
        .o_ic_req_addr        (req_addr),
        .i_ic_req_ready       (ready),
        .i_ic_resp_valid      (resp_valid),
        .i_ic_resp_data       (resp_data),
`ifdef FETCH_PERF_EN
        .o_perf_credit_stall  (perf_stall),
        .o_perf_squashed      (perf_sq),
`endif
        .i_redirect_valid     (redir),
        .i_redirect_pc        (redir_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [IB_PUSH_WIDTH*32-1:0] rdata(input logic [31:0] base);
        logic [IB_PUSH_WIDTH*32-1:0] d;
        for (int i = 0; i < IB_PUSH_WIDTH; i++) d[32*i +: 32] = mem_word(base + 32'(4 * i));
        return d;
    endfunction

    // Expected IB push for a block fetched at pc (16-byte blocks, 4 lanes).
    function automatic push_t pkt(input logic [31:0] pc);
        push_t       p;
        logic [31:0] base;
        int          off;
        p    = '0;
        base = pc & ~32'hF;
        off  = int'(pc[3:2]);
        for (int i = 0; i < IB_PUSH_WIDTH; i++) begin
            if (i >= off) begin
                p[i].inst  = mem_word(base + 32'(4 * i));
                p[i].PC    = base + 32'(4 * i);
                p[i].NPC   = base + 32'(4 * i + 4);
                p[i].valid = 1'b1;
            end
        end
        return p;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic req(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, req_valid, 1'b1);
        chk({tag, "_addr"}, req_addr, pc & ~32'hF);
        if (ready) sb.push_back(pkt(pc));
    endtask

    task automatic resp(input string tag);
        push_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s observed=response expected=no_outstanding_entry", tag);
        end else begin
            e = sb.pop_front();
            chk(tag, push, e);
        end
    endtask

    task automatic squash();
        foreach (sb[k]) sb[k] = '0;
    endtask

    initial begin
        reset = 1'b1; slots = 5'd16; ready = 1'b1; resp_valid = 1'b0;
        resp_data = '0; redir = 1'b0; redir_pc = '0;
        tick(); tick(); settle();
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_push", push, '0);

        // Streaming: one response per cycle behind the requests
        tick(); reset = 1'b0; settle();
        req("t1_req0", 32'h0);
        tick(); resp_valid = 1'b1; resp_data = rdata(32'h0); settle();
        resp("t1_push0");
        req("t1_req1", 32'h10);
        tick(); resp_data = rdata(32'h10); ready = 1'b0; settle();
        resp("t1_push1");

        // Credit boundary: live=1 needs 8 slots
        tick(); resp_valid = 1'b0; ready = 1'b1; settle();
        req("t2_req2", 32'h20);
        tick(); slots = 5'd7; settle();
        chk("t2_credit_block", req_valid, 1'b0);
        tick(); slots = 5'd8; settle();
        req("t2_req3", 32'h30);

        // Redirect with two in flight
        tick(); slots = 5'd16; redir = 1'b1; redir_pc = 32'h108; settle();
        squash();
        chk("t3_flush", flush, 1'b1);
        chk("t3_redir_noreq", req_valid, 1'b0);
        tick(); redir = 1'b0; resp_valid = 1'b1; resp_data = rdata(32'h20); settle();
        chk("t3_flush_once", flush, 1'b0);
        chk("t3_full_noreq", req_valid, 1'b0);
        resp("t3_drop0");
        tick(); resp_data = rdata(32'h30); settle();
        resp("t3_drop1");
        req("t3_req_new", 32'h108);
        tick(); resp_data = rdata(32'h100); ready = 1'b0; settle();
        resp("t3_push_lanes23");

        // Redirect and response in the same cycle, one in flight
        tick(); resp_valid = 1'b0; ready = 1'b1; settle();
        req("t4_req", 32'h110);
        tick(); redir = 1'b1; redir_pc = 32'h200; resp_valid = 1'b1; resp_data = rdata(32'h110); settle();
        squash();
        chk("t4_flush", flush, 1'b1);
        chk("t4_redir_noreq", req_valid, 1'b0);
        resp("t4_drop");
        tick(); redir = 1'b0; resp_valid = 1'b0; settle();
        req("t4_req_next", 32'h200);
        tick(); resp_valid = 1'b1; resp_data = rdata(32'h200); ready = 1'b0; settle();
        resp("t4_live_push");

        // Reset with two requests in flight
        tick(); resp_valid = 1'b0; ready = 1'b1; settle();
        req("t5_req_a", 32'h210);
        tick(); settle();
        req("t5_req_b", 32'h220);
        tick(); reset = 1'b1; settle();
        sb.delete();
        chk("t5_rst_req_valid", req_valid, 1'b0);
        tick(); reset = 1'b0; resp_valid = 1'b1; resp_data = rdata(32'h210); ready = 1'b0; settle();
        chk("t5_late_push0", push, '0);
        chk("t5_flush", flush, 1'b0);
        req("t5_first_req", 32'h0);
        tick(); resp_data = rdata(32'h220); ready = 1'b1; settle();
        chk("t5_late_push1", push, '0);
        req("t5_req0_acc", 32'h0);
        tick(); resp_data = rdata(32'h0); ready = 1'b0; settle();
        resp("t5_push0");

`ifdef FETCH_PERF_EN
        tick(); resp_valid = 1'b0; slots = 5'd0; settle();
        chk("t6_stall_start", perf_stall, 32'd0);
        chk("t6_noreq", req_valid, 1'b0);
        repeat (4) tick();
        tick(); slots = 5'd16; ready = 1'b1; settle();
        chk("t6_credit_stall", perf_stall, 32'd5);
        req("t6_req_a", 32'h10);
        tick(); settle();
        req("t6_req_b", 32'h20);
        tick(); redir = 1'b1; redir_pc = 32'h300; ready = 1'b0; settle();
        squash();
        chk("t6_flush", flush, 1'b1);
        tick(); redir = 1'b0; resp_valid = 1'b1; resp_data = rdata(32'h10); settle();
        resp("t6_drop0");
        tick(); resp_data = rdata(32'h20); settle();
        resp("t6_drop1");
        tick(); resp_valid = 1'b0; settle();
        chk("t6_squashed", perf_sq, 32'd2);
        chk("t6_stall_hold", perf_stall, 32'd5);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
